// File: rtl/cmd_engine_pkg.sv
// Shared types for the chunked command engine: opcodes, completion status,
// FSM states and the burst-count width helper.
package cmd_engine_pkg;

   typedef enum logic [1:0] {
      OP_COPY   = 2'd0,
      OP_FILL   = 2'd1,
      OP_SUM    = 2'd2,
      OP_SGCOPY = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      STS_OK     = 2'd0,
      STS_BADLEN = 2'd1,
      STS_RDERR  = 2'd2,
      STS_WRERR  = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_NEXT, S_CPL
   } state_e;

   function automatic int cw_of(input int chunk);
      return $clog2(chunk + 1);
   endfunction

endpackage

// File: rtl/cmd_chunk_sizer.sv
// Burst sizing: n = min(left, CHUNK[, seg_left]) plus flags telling the
// engine whether this burst finishes the command and/or the current segment.
module cmd_chunk_sizer #(
   parameter int LEN_W = 16,
   parameter int CHUNK = 4,
   parameter int CW    = 3
) (
   input  logic [LEN_W-1:0] left,
   input  logic [LEN_W-1:0] seg_left,
   input  logic             sg,
   output logic [CW-1:0]    n,
   output logic             last,
   output logic             seg_end
);

   logic [LEN_W-1:0] m;

   always_comb begin
      m = (left < LEN_W'(CHUNK)) ? left : LEN_W'(CHUNK);
      if (sg && (seg_left < m)) m = seg_left;
      n       = CW'(m);
      last    = (m == left);
      seg_end = sg && (m == seg_left);
   end

endmodule

// File: rtl/cmd_chunk_engine.sv
// Command processor: splits one COPY/FILL/SUM/SGCOPY command into bursts of
// at most CHUNK words on the read/write ports and posts one completion record.
module cmd_chunk_engine
   import cmd_engine_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int CHUNK      = 4,
   parameter int ID_W       = 4,
   parameter int SUM_W      = 32,
   parameter int DST_STRIDE = 8,
   localparam int CW        = cw_of(CHUNK)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [ADDR_W-1:0]       cmd_src,
   input  logic [ADDR_W-1:0]       cmd_dst,
   input  logic [LEN_W-1:0]        cmd_len,
   input  logic [LEN_W-1:0]        cmd_seg,
   input  logic [ID_W-1:0]         cmd_id,
   output logic                    rd_start,
   output logic [ADDR_W-1:0]       rd_addr,
   output logic [CW-1:0]           rd_cnt,
   input  logic                    rd_done,
   input  logic                    rd_err,
   input  logic [CHUNK*DATA_W-1:0] rd_data,
   output logic                    wr_start,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [CW-1:0]           wr_cnt,
   output logic [CHUNK*DATA_W-1:0] wr_data,
   input  logic                    wr_done,
   input  logic                    wr_err,
   output logic                    cpl_valid,
   input  logic                    cpl_ready,
   output logic [ID_W-1:0]         cpl_id,
   output logic [1:0]              cpl_status,
   output logic [SUM_W-1:0]        cpl_sum
);

   state_e                  state, nxt;
   op_e                     op;
   status_e                 status;
   logic [ID_W-1:0]         id;
   logic [ADDR_W-1:0]       src, dst, seg_base;
   logic [LEN_W-1:0]        left, seg_left, seg_len;
   logic [SUM_W-1:0]        sum;
   logic [CHUNK*DATA_W-1:0] burst;
   logic [CW-1:0]           n;
   logic                    last, seg_end, badlen;

   // Words past n are ignored; each word is truncated to SUM_W and wraps.
   function automatic logic [SUM_W-1:0] sum_burst(input logic [SUM_W-1:0]        acc,
                                                  input logic [CHUNK*DATA_W-1:0] d,
                                                  input logic [CW-1:0]           cnt);
      logic [SUM_W-1:0] s;
      s = acc;
      for (int i = 0; i < CHUNK; i++)
         if (i < int'(cnt)) s = s + SUM_W'(d[i*DATA_W +: DATA_W]);
      return s;
   endfunction

   cmd_chunk_sizer #(.LEN_W(LEN_W), .CHUNK(CHUNK), .CW(CW)) u_sizer (
      .left     (left),
      .seg_left (seg_left),
      .sg       (op == OP_SGCOPY),
      .n        (n),
      .last     (last),
      .seg_end  (seg_end)
   );

   assign badlen = (left == '0) || ((op == OP_SGCOPY) && (seg_len == '0));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt       = state;
      cmd_ready = 1'b0;
      rd_start  = 1'b0;
      wr_start  = 1'b0;
      cpl_valid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) nxt = S_DECODE;
         end
         S_DECODE: begin
            if (badlen)              nxt = S_CPL;
            else if (op == OP_FILL)  nxt = S_WR_REQ;
            else                     nxt = S_RD_REQ;
         end
         S_RD_REQ: begin
            rd_start = 1'b1;
            nxt      = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (rd_done) begin
               if (rd_err)            nxt = S_CPL;
               else if (op == OP_SUM) nxt = S_NEXT;
               else                   nxt = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            wr_start = 1'b1;
            nxt      = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (wr_done) nxt = wr_err ? S_CPL : S_NEXT;
         end
         S_NEXT: begin
            if (last)               nxt = S_CPL;
            else if (op == OP_FILL) nxt = S_WR_REQ;
            else                    nxt = S_RD_REQ;
         end
         S_CPL: begin
            cpl_valid = 1'b1;
            if (cpl_ready) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Command context and burst data; outputs are gated by state, so no reset needed here.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: if (cmd_valid) begin
            op       <= op_e'(cmd_op);
            id       <= cmd_id;
            src      <= cmd_src;
            dst      <= cmd_dst;
            seg_base <= cmd_dst;
            left     <= cmd_len;
            seg_len  <= cmd_seg;
            seg_left <= cmd_seg;
            sum      <= '0;
            status   <= STS_OK;
         end
         S_DECODE: if (badlen) status <= STS_BADLEN;
         S_RD_WAIT: if (rd_done) begin
            if (rd_err) status <= STS_RDERR;
            else begin
               burst <= rd_data;
               if (op == OP_SUM) sum <= sum_burst(sum, rd_data, n);
            end
         end
         S_WR_WAIT: if (wr_done && wr_err) status <= STS_WRERR;
         S_NEXT: begin
            left <= left - LEN_W'(n);
            src  <= src + ADDR_W'(n);
            if (seg_end) begin
               dst      <= seg_base + ADDR_W'(DST_STRIDE);
               seg_base <= seg_base + ADDR_W'(DST_STRIDE);
               seg_left <= seg_len;
            end else begin
               dst      <= dst + ADDR_W'(n);
               seg_left <= seg_left - LEN_W'(n);
            end
         end
         default: ;
      endcase
   end

   assign rd_addr    = rd_start ? src : '0;
   assign rd_cnt     = rd_start ? n : '0;
   assign wr_addr    = wr_start ? dst : '0;
   assign wr_cnt     = wr_start ? n : '0;
   assign wr_data    = (wr_start && (op != OP_FILL)) ? burst : '0;
   assign cpl_id     = cpl_valid ? id : '0;
   assign cpl_status = cpl_valid ? status : '0;
   assign cpl_sum    = cpl_valid ? sum : '0;

endmodule
